// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with registered match pulse.
// Supports overlapping/non-overlapping detection and a saturating match counter.
module seq_detector_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = 8'b0000_0111,
    parameter logic [LEN_W-1:0]   DEFAULT_LEN = 4'd4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_n;
    logic               pat_eq;
    logic               match;

    always_comb begin
        hist_n   = {hist_q[MAX_LEN-2:0], in};
        fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
        fill_n   = (fill_inc > {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];

        // Only the low len bits of history and pattern take part in the compare
        pat_eq = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(len_q)) && (hist_n[i] != pat_q[i])) begin
                pat_eq = 1'b0;
            end
        end

        match = in_valid && !cfg_load && (fill_n == len_q)
              && pat_eq && (len_q != '0);
    end

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        out_d     = match;

        if (cfg_load) begin
            pat_d     = cfg_pattern;
            len_d     = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            hist_d = hist_n;
            fill_d = (match && !overlap_q) ? '0 : fill_n;
        end

        cnt_d = cnt_clr ? '0 : cnt_q;
        if (match && (cnt_d != '1)) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= DEFAULT_PAT;
            len_q     <= DEFAULT_LEN;
            overlap_q <= 1'b1;
            out_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Randomised and directed bench for seq_detector_prog against a
// bit-queue reference model of the detection rules.
module tb_seq_detector_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = 8'h07;
    logic [3:0] cfg_len = 4'd4;
    logic       cfg_overlap = 1'b1;
    logic       cnt_clr = 1'b0;
    logic       out, out2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    int checks = 0;
    int errors = 0;

    bit       m_q[$];
    int       m_since;
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ov;
    bit       m_out;
    int       m_cnt;
    int       m_cnt2;

    always #5 clk = ~clk;

    seq_detector_prog u_dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .out(out), .match_cnt(match_cnt)
    );

    seq_detector_prog #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .out(out2), .match_cnt(match_cnt2)
    );

    // Matches are judged on the bits seen since the last restart point.
    task automatic model_step();
        bit m;
        m = 1'b0;
        if (!rst) begin
            m_q.delete();
            m_since = 0;
            m_pat = 8'h07;
            m_len = 4;
            m_ov = 1'b1;
            m_out = 1'b0;
            m_cnt = 0;
            m_cnt2 = 0;
            return;
        end
        if (cfg_load) begin
            m_pat = cfg_pattern;
            m_len = (cfg_len > 4'd8) ? 8 : int'(cfg_len);
            m_ov = cfg_overlap;
            m_q.delete();
            m_since = 0;
        end else if (in_valid) begin
            m_q.push_back(in);
            if (m_q.size() > 16) void'(m_q.pop_front());
            m_since++;
            if (m_len != 0 && m_since >= m_len) begin
                m = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (m_q[m_q.size()-1-i] != m_pat[i]) m = 1'b0;
            end
            if (m && !m_ov) m_since = 0;
        end
        m_out = m;
        if (cnt_clr) begin
            m_cnt = 0;
            m_cnt2 = 0;
        end
        if (m) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc(input bit b, input bit v);
        rst = 1'b1;
        cfg_load = 1'b0;
        in = b;
        in_valid = v;
        tick();
    endtask

    task automatic load(input bit [7:0] p, input bit [3:0] l, input bit o);
        rst = 1'b1;
        cfg_pattern = p;
        cfg_len = l;
        cfg_overlap = o;
        cfg_load = 1'b1;
        in = 1'($urandom);
        in_valid = 1'($urandom);
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in = 1'b1;
        in_valid = 1'b1;
        cfg_load = 1'($urandom);
        cnt_clr = 1'($urandom);
        tick();
        rst = 1'b1;
        cfg_load = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out !== 1'b0 || match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL reset out=%b cnt=%0d cnt2=%0d required 0/0/0",
                     out, match_cnt, match_cnt2);
        end
    endtask

    task automatic test_default_stream();
        bit bits[8] = '{0, 1, 1, 1, 0, 1, 1, 1};
        bit ex[8]   = '{0, 0, 0, 1, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            cyc(bits[i], 1'b1);
            checks++;
            if (out !== ex[i] || out !== m_out) begin
                errors++;
                $display("FAIL default_out bit %0d got %b required %b", i, out, ex[i]);
            end
        end
        checks++;
        if (match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL default_cnt got %0d required 2", match_cnt);
        end
    endtask

    task automatic test_overlap();
        bit ex[4] = '{0, 1, 1, 1};
        cnt_clr = 1'b1;
        load(8'b11, 4'd2, 1'b1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1);
            checks++;
            if (out !== ex[i]) begin
                errors++;
                $display("FAIL overlap_out bit %0d got %b required %b", i, out, ex[i]);
            end
        end
        checks++;
        if (match_cnt !== 8'd3) begin
            errors++;
            $display("FAIL overlap_cnt got %0d required 3", match_cnt);
        end
    endtask

    task automatic test_nonoverlap();
        bit ex[4] = '{0, 1, 0, 1};
        cnt_clr = 1'b1;
        load(8'b11, 4'd2, 1'b0);
        cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1);
            checks++;
            if (out !== ex[i]) begin
                errors++;
                $display("FAIL nonoverlap_out bit %0d got %b required %b", i, out, ex[i]);
            end
        end
        checks++;
        if (match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL nonoverlap_cnt got %0d required 2", match_cnt);
        end
    endtask

    task automatic test_valid_gaps();
        bit bits[4] = '{0, 1, 1, 1};
        cnt_clr = 1'b1;
        load(8'h07, 4'd4, 1'b1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(bits[i], 1'b1);
            checks++;
            if (out !== (i == 3)) begin
                errors++;
                $display("FAIL gap_valid bit %0d got %b required %b", i, out, (i == 3));
            end
            cyc(1'($urandom), 1'b0);
            checks++;
            if (out !== 1'b0) begin
                errors++;
                $display("FAIL gap_invalid after bit %0d got %b required 0", i, out);
            end
        end
        checks++;
        if (match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL gap_cnt got %0d required 1", match_cnt);
        end
    endtask

    task automatic test_cfg_abort();
        load(8'h07, 4'd4, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        load(8'h07, 4'd4, 1'b1);
        cyc(1'b1, 1'b1);
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL cfg_abort got %b required 0", out);
        end
    endtask

    task automatic test_reset_abort();
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        do_reset();
        cyc(1'b1, 1'b1);
        checks++;
        if (out !== 1'b0 || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_abort out=%b cnt=%0d required 0/0", out, match_cnt);
        end
    endtask

    task automatic test_saturation();
        bit [1:0] ex2[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        cnt_clr = 1'b1;
        load(8'h01, 4'd1, 1'b1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1);
            checks++;
            if (match_cnt2 !== ex2[i] || match_cnt !== 8'(i + 1)) begin
                errors++;
                $display("FAIL sat_step %0d cnt2=%0d cnt=%0d required %0d/%0d",
                         i, match_cnt2, match_cnt, ex2[i], i + 1);
            end
        end
        cnt_clr = 1'b1;
        cyc(1'b1, 1'b1);
        checks++;
        if (match_cnt2 !== 2'd1 || match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL clr_with_match cnt2=%0d cnt=%0d required 1/1",
                     match_cnt2, match_cnt);
        end
        cyc(1'b0, 1'b1);
        cnt_clr = 1'b0;
        checks++;
        if (match_cnt2 !== 2'd0 || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_alone cnt2=%0d cnt=%0d required 0/0",
                     match_cnt2, match_cnt);
        end
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1);
        checks++;
        if (match_cnt !== 8'd255 || match_cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL sat_hold cnt=%0d cnt2=%0d required 255/3",
                     match_cnt, match_cnt2);
        end
    endtask

    task automatic test_len_zero();
        load(8'($urandom), 4'd0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cyc(1'($urandom), 1'b1);
            checks++;
            if (out !== 1'b0) begin
                errors++;
                $display("FAIL len_zero cycle %0d got %b required 0", i, out);
            end
        end
    endtask

    task automatic test_clamp();
        bit [7:0] p = 8'hB4;
        load(p, 4'd12, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            cyc(p[i], 1'b1);
            checks++;
            if (out !== (i == 0)) begin
                errors++;
                $display("FAIL clamp bit %0d got %b required %b", i, out, (i == 0));
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            bit [3:0] l;
            l = (r % 3 == 2) ? 4'($urandom_range(5, 12)) : 4'($urandom_range(0, 4));
            load(8'($urandom), l, 1'($urandom));
            for (int i = 0; i < 200; i++) begin
                cnt_clr = (($urandom % 16) == 0);
                if (($urandom % 500) == 0) do_reset();
                else cyc(1'($urandom), ($urandom % 4) != 0);
                checks++;
                if (out !== m_out || out2 !== m_out
                    || match_cnt !== 8'(m_cnt) || match_cnt2 !== 2'(m_cnt2)) begin
                    errors++;
                    $display("FAIL random r%0d c%0d out=%b/%b cnt=%0d/%0d required out=%b cnt=%0d/%0d",
                             r, i, out, out2, match_cnt, match_cnt2, m_out, m_cnt, m_cnt2);
                end
            end
            cnt_clr = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_overlap();
        test_nonoverlap();
        test_valid_gaps();
        test_cfg_abort();
        test_reset_abort();
        test_saturation();
        test_len_zero();
        test_clamp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Runtime-programmable, parametrised serial pattern detector with a registered (Moore) match output.
- Generalises the fixed 4-bit "0111" detector in three ways:
  - pattern length up to MAX_LEN, loaded at run time;
  - selectable overlapping or non-overlapping detection;
  - input-valid qualifier and a saturating match counter.
- Sits on a serial bit stream feeding framing/sync logic; the counter is read by control software.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..16).
- LEN_W, 4, width of the length field; must hold MAX_LEN.
- CNT_W, 8, match counter width.
- DEFAULT_PAT, 8'b0000_0111, pattern after reset (LSB = last bit received).
- DEFAULT_LEN, 4, pattern length after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on the rising edge of clk).
- in  in  1  serial data bit.
- in_valid  in  1  qualifies in; the bit is consumed only when high.
- cfg_load  in  1  one-cycle strobe; latches cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern. Bit cfg_len-1 is matched first, bit 0 last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  clears match_cnt.
- out  out  1  match pulse, high one cycle per detected pattern.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst==0 at a clk edge) sets:
  - hist=0, fill=0, out=0, match_cnt=0;
  - pat=DEFAULT_PAT, len=DEFAULT_LEN, overlap=1.
  - Reset wins over all other inputs and aborts any partial match.
- State:
  - hist[MAX_LEN-1:0] shift register; newest bit at hist[0].
  - fill = number of valid bits in the history, saturating at len.
  - Configuration registers: pat, len, overlap.
- Valid bit (in_valid=1, cfg_load=0), computed on the updated values:
  - hist_n = {hist[MAX_LEN-2:0], in}.
  - fill_n = min(fill+1, len).
  - match = (fill_n==len) && (hist_n[len-1:0] == pat[len-1:0]) && (len!=0).
- Register updates on a valid bit:
  - hist <= hist_n; out <= match.
  - If match and overlap==0: fill <= 0. Otherwise fill <= fill_n.
- Latency:
  - out rises on the clk edge that samples the final pattern bit (registered, no combinational path from in).
  - out is high for exactly one cycle.
- in_valid=0: hist and fill hold; out <= 0. Gaps in in_valid do not break a partial match.
- cfg_load=1:
  - Latch the new configuration; clear hist and fill; out <= 0.
  - The in bit in the same cycle is discarded.
  - Match detection restarts from an empty history.
- Length rules:
  - cfg_len > MAX_LEN is clamped to MAX_LEN.
  - cfg_len==0 disables detection: out stays 0, hist still shifts.
- match_cnt:
  - Increments on each cycle where out is loaded with 1; saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr alone sets the counter to 0.
  - cnt_clr together with a match sets it to 1 (clear then count).
  - cnt_clr has no effect on detection.
- Overlap example, pattern 11, len=2, input 1111:
  - overlap=1 → 3 matches.
  - overlap=0 → 2 matches.
- FSM summary, with fill as the state variable:
  - EMPTY (fill=0) → FILLING (0<fill<len) → ARMED (fill==len).
  - ARMED → EMPTY on a match when non-overlapping.
  - Any state → EMPTY on cfg_load or reset.

Test Plan:
- Defaults after reset; stream 0,1,1,1,0,1,1,1 → out high on the cycles after the 4th and 8th valid bits; match_cnt=2.
- cfg_load pat=2'b11, len=2, overlap=1; stream 1,1,1,1 → 3 out pulses (after bits 2, 3, 4).
- Repeat with overlap=0 → 2 pulses (after bits 2 and 4); match_cnt=2.
- Default pattern, in_valid toggling 1,0,1,0 around bits 0,1,1,1 → single pulse on the final valid bit; out=0 on every invalid cycle.
- cfg_load mid-pattern after 0,1,1, then bit 1 → no pulse. Reset asserted after 0,1,1, then 1 → no pulse and match_cnt=0.
- CNT_W=2, pat=1'b1, len=1, six 1s → match_cnt 1,2,3,3,3,3. cnt_clr on the 6th bit → match_cnt=1. cfg_len=0 → out never asserts.
